// File: rtl/aes_axil_pkg.sv
// Shared register map, response codes and helpers for the AES data AXI4-Lite slave.
package aes_axil_pkg;

    localparam logic [5:0] ADDR_DATA0   = 6'h00;
    localparam logic [5:0] ADDR_DATA1   = 6'h04;
    localparam logic [5:0] ADDR_DATA2   = 6'h08;
    localparam logic [5:0] ADDR_DATA3   = 6'h0C;
    localparam logic [5:0] ADDR_CTRL    = 6'h10;
    localparam logic [5:0] ADDR_STATUS  = 6'h14;
    localparam logic [5:0] ADDR_RESULT0 = 6'h20;
    localparam logic [5:0] ADDR_RESULT1 = 6'h24;
    localparam logic [5:0] ADDR_RESULT2 = 6'h28;
    localparam logic [5:0] ADDR_RESULT3 = 6'h2C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_START_BIT  = 0;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

    // Takes the word index (byte address bits [5:2]).
    function automatic logic addr_is_mapped(input logic [3:0] word);
        case (word)
            ADDR_DATA0[5:2], ADDR_DATA1[5:2], ADDR_DATA2[5:2], ADDR_DATA3[5:2],
            ADDR_CTRL[5:2], ADDR_STATUS[5:2],
            ADDR_RESULT0[5:2], ADDR_RESULT1[5:2], ADDR_RESULT2[5:2], ADDR_RESULT3[5:2]:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/aes_axil_wr_ctrl.sv
// AXI4-Lite write path: independent AW/W capture, single commit cycle, B response.
module aes_axil_wr_ctrl
    import aes_axil_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic        wr_en,
    output logic [5:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HAVE_AW = 3'd1;
    localparam logic [2:0] S_HAVE_W  = 3'd2;
    localparam logic [2:0] S_COMMIT  = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    wr_req_t    req;
    logic       aw_hs;
    logic       w_hs;

    assign awready = ~reset & ((state == S_IDLE) | (state == S_HAVE_W));
    assign wready  = ~reset & ((state == S_IDLE) | (state == S_HAVE_AW));
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (aw_hs && w_hs) state_nxt = S_COMMIT;
                else if (aw_hs)    state_nxt = S_HAVE_AW;
                else if (w_hs)     state_nxt = S_HAVE_W;
            end
            S_HAVE_AW: if (w_hs)  state_nxt = S_COMMIT;
            S_HAVE_W:  if (aw_hs) state_nxt = S_COMMIT;
            S_COMMIT:  state_nxt = bready ? S_IDLE : S_RESP;
            S_RESP:    if (bready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Held request needs no reset: it is only consumed in COMMIT/RESP.
    always_ff @(posedge clock) begin
        if (aw_hs) req.addr <= awaddr;
        if (w_hs) begin
            req.data <= wdata;
            req.strb <= wstrb;
        end
    end

    assign bvalid  = (state == S_COMMIT) | (state == S_RESP);
    assign bresp   = (bvalid && !addr_is_mapped(req.addr[5:2])) ? RESP_SLVERR : RESP_OKAY;
    assign wr_en   = (state == S_COMMIT);
    assign wr_addr = req.addr;
    assign wr_data = req.data;
    assign wr_strb = req.strb;

endmodule

// File: rtl/aes_data_axil_slave.sv
// AXI4-Lite register bank feeding the AES-128 core: input block, start/busy/done, result.
module aes_data_axil_slave
    import aes_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [127:0]                    aes_data_o,
    output logic                            aes_start_o,
    input  logic                            aes_done_i,
    input  logic [127:0]                    aes_result_i
);

    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] data_reg [4];
    logic [31:0] result_reg [4];
    logic        busy;
    logic        done;
    logic        start_q;
    logic [31:0] rd_word;
    logic        rd_mapped;
    logic        unused_ok;

    aes_axil_wr_ctrl u_wr_ctrl (
        .clock   (clock),
        .reset   (reset),
        .awaddr  (s_axi_awaddr),
        .awvalid (s_axi_awvalid),
        .awready (s_axi_awready),
        .wdata   (s_axi_wdata),
        .wstrb   (s_axi_wstrb),
        .wvalid  (s_axi_wvalid),
        .wready  (s_axi_wready),
        .bresp   (s_axi_bresp),
        .bvalid  (s_axi_bvalid),
        .bready  (s_axi_bready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb)
    );

    // Register updates; a core completion is applied last so its DONE set beats a W1C.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                data_reg[i]   <= '0;
                result_reg[i] <= '0;
            end
            busy    <= 1'b0;
            done    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (wr_en) begin
                if (wr_addr[5:4] == 2'b00) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) data_reg[wr_addr[3:2]][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
                if (wr_addr[5:2] == ADDR_CTRL[5:2] && wr_data[CTRL_START_BIT] && !busy) begin
                    start_q <= 1'b1;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                end
                if (wr_addr[5:2] == ADDR_STATUS[5:2] && wr_data[STATUS_DONE_BIT]) done <= 1'b0;
            end
            if (aes_done_i) begin
                busy <= 1'b0;
                done <= 1'b1;
                for (int i = 0; i < 4; i++) result_reg[i] <= aes_result_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        rd_word   = '0;
        rd_mapped = addr_is_mapped(s_axi_araddr[5:2]);
        case (s_axi_araddr[5:2])
            ADDR_DATA0[5:2], ADDR_DATA1[5:2], ADDR_DATA2[5:2], ADDR_DATA3[5:2]:
                rd_word = data_reg[s_axi_araddr[3:2]];
            ADDR_STATUS[5:2]: begin
                rd_word[STATUS_BUSY_BIT] = busy;
                rd_word[STATUS_DONE_BIT] = done;
            end
            ADDR_RESULT0[5:2], ADDR_RESULT1[5:2], ADDR_RESULT2[5:2], ADDR_RESULT3[5:2]:
                rd_word = result_reg[s_axi_araddr[3:2]];
            default: rd_word = '0;
        endcase
    end

    assign s_axi_arready = ~reset & ~s_axi_rvalid;

    // Read sampling shares the commit edge, so a colliding read sees the pre-write value.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_word;
            s_axi_rresp  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    assign aes_data_o  = {data_reg[3], data_reg[2], data_reg[1], data_reg[0]};
    assign aes_start_o = start_q;
    assign unused_ok   = ^{s_axi_awprot, s_axi_arprot, s_axi_araddr[1:0], wr_addr[1:0]};

endmodule

// File: tb/tb_aes_data_axil_slave.sv
// Self-checking bench for aes_data_axil_slave: vector table, directed corner cases, random vs model.
module tb_aes_data_axil_slave;

    logic         clock;
    logic         reset;
    logic [5:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [5:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] aes_data_o;
    logic         aes_start_o;
    logic         aes_done_i;
    logic [127:0] aes_result_i;

    aes_data_axil_slave dut (
        .clock         (clock),
        .reset         (reset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .aes_data_o    (aes_data_o),
        .aes_start_o   (aes_start_o),
        .aes_done_i    (aes_done_i),
        .aes_result_i  (aes_result_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = -1;
    int last_bcyc = 0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (aes_start_o === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
    end

    // Reference model: the register map as plain arrays and flags.
    logic [31:0] m_data [4];
    logic [31:0] m_result [4];
    bit          m_busy;
    bit          m_done;
    int          m_starts = 0;

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            m_data[i]   = '0;
            m_result[i] = '0;
        end
        m_busy = 0;
        m_done = 0;
    endfunction

    function automatic logic [1:0] m_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int w = int'(a) / 4;
        if (w < 4) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_data[w][8*b +: 8] = d[8*b +: 8];
            return 2'b00;
        end
        if (w == 4) begin
            if (d[0] && !m_busy) begin
                m_busy = 1;
                m_done = 0;
                m_starts++;
            end
            return 2'b00;
        end
        if (w == 5) begin
            if (d[1]) m_done = 0;
            return 2'b00;
        end
        if (w >= 8 && w < 12) return 2'b00;
        return 2'b10;
    endfunction

    function automatic void m_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int w = int'(a) / 4;
        d = '0;
        r = 2'b00;
        if (w < 4)                 d = m_data[w];
        else if (w == 4)           d = '0;
        else if (w == 5)           d = {30'b0, m_done, m_busy};
        else if (w >= 8 && w < 12) d = m_result[w-8];
        else                       r = 2'b10;
    endfunction

    function automatic void m_done_pulse(input logic [127:0] res);
        m_busy = 0;
        m_done = 1;
        for (int i = 0; i < 4; i++) m_result[i] = res[32*i +: 32];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs;
        bit w_hs;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1; bready = 1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clock);
            n++;
            if (aw_hs) begin awvalid = 0; aw_done = 1; end
            if (w_hs)  begin wvalid = 0;  w_done = 1;  end
        end
        awvalid = 0; wvalid = 0;
        check("wr_accept", aw_done && w_done, 1);
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clock); n++; end
        check("wr_bvalid", bvalid, 1);
        resp = bresp;
        last_bcyc = cyc;
        @(negedge clock);
        bready = 0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit done_f = 0;
        bit hs;
        int n = 0;
        araddr = a; arvalid = 1; rready = 1;
        while (!done_f && n < 20) begin
            hs = arvalid && arready;
            @(negedge clock);
            n++;
            if (hs) begin arvalid = 0; done_f = 1; end
        end
        arvalid = 0;
        check("rd_accept", done_f, 1);
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clock); n++; end
        check("rd_rvalid", rvalid, 1);
        d = rdata;
        resp = rresp;
        @(negedge clock);
        rready = 0;
    endtask

    task automatic pulse_done(input logic [127:0] res);
        aes_done_i = 1;
        aes_result_i = res;
        @(negedge clock);
        aes_done_i = 0;
        m_done_pulse(res);
    endtask

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d limit=50000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        logic [1:0]  er;
        logic [31:0] ed;
        int          s0;

        vecs[0] = '{6'h00, 32'h00000001, 4'hF, 2'b00, 32'h00000001, 2'b00};
        vecs[1] = '{6'h04, 32'h00000002, 4'hF, 2'b00, 32'h00000002, 2'b00};
        vecs[2] = '{6'h08, 32'h00000003, 4'hF, 2'b00, 32'h00000003, 2'b00};
        vecs[3] = '{6'h0C, 32'h00000004, 4'hF, 2'b00, 32'h00000004, 2'b00};
        vecs[4] = '{6'h18, 32'hDEADBEEF, 4'hF, 2'b10, 32'h00000000, 2'b10};
        vecs[5] = '{6'h30, 32'h12345678, 4'hF, 2'b10, 32'h00000000, 2'b10};
        vecs[6] = '{6'h20, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h00000000, 2'b00};
        vecs[7] = '{6'h10, 32'h00000000, 4'hF, 2'b00, 32'h00000000, 2'b00};
        vecs[8] = '{6'h0B, 32'hA5A5A5A5, 4'b1000, 2'b00, 32'hA5000003, 2'b00};
        vecs[9] = '{6'h14, 32'h00000002, 4'hF, 2'b00, 32'h00000000, 2'b00};

        reset = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        aes_done_i = 0; aes_result_i = '0;
        m_reset();
        repeat (3) @(negedge clock);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_start", aes_start_o, 0);
        check("rst_data_o", aes_data_o, 0);
        reset = 0;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, r);
            void'(m_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb));
            check($sformatf("vec%0d_bresp", i), r, vecs[i].exp_bresp);
            axi_read(vecs[i].addr, d, r);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rresp", i), r, vecs[i].exp_rresp);
            if (i == 3) check("data_o_1234", aes_data_o, 128'h00000004_00000003_00000002_00000001);
        end
        check("data_o_after_table", aes_data_o, 128'h00000004_A5000003_00000002_00000001);
        check("no_start_yet", start_cnt, 0);

        // START and completion
        s0 = start_cnt;
        axi_write(6'h10, 32'h1, 4'hF, r);
        void'(m_write(6'h10, 32'h1, 4'hF));
        @(negedge clock);
        check("start_bresp", r, 2'b00);
        check("start_timing", start_cyc, last_bcyc + 1);
        repeat (2) @(negedge clock);
        check("start_one_pulse", start_cnt - s0, 1);
        axi_read(6'h14, d, r);
        check("status_busy", d, 32'h1);
        pulse_done(128'h01234567_89ABCDEF_FEDCBA98_76543210);
        axi_read(6'h14, d, r);
        check("status_done", d, 32'h2);
        axi_read(6'h20, d, r); check("result0", d, 32'h76543210);
        axi_read(6'h24, d, r); check("result1", d, 32'hFEDCBA98);
        axi_read(6'h28, d, r); check("result2", d, 32'h89ABCDEF);
        axi_read(6'h2C, d, r); check("result3", d, 32'h01234567);

        // START while busy is ignored
        s0 = start_cnt;
        axi_write(6'h10, 32'h1, 4'hF, r);
        void'(m_write(6'h10, 32'h1, 4'hF));
        axi_write(6'h10, 32'h1, 4'hF, r);
        void'(m_write(6'h10, 32'h1, 4'hF));
        check("busy_start_bresp", r, 2'b00);
        repeat (3) @(negedge clock);
        check("busy_start_ignored", start_cnt - s0, 1);

        // DONE W1C in the same cycle as aes_done_i: set wins
        awaddr = 6'h14; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        @(negedge clock);
        awvalid = 0; wvalid = 0;
        check("w1c_commit_cycle", bvalid, 1);
        aes_done_i = 1; aes_result_i = 128'h11111111_22222222_33333333_44444444;
        @(negedge clock);
        aes_done_i = 0; bready = 0;
        void'(m_write(6'h14, 32'h2, 4'hF));
        m_done_pulse(128'h11111111_22222222_33333333_44444444);
        axi_read(6'h14, d, r);
        check("done_set_wins", d, 32'h2);
        axi_write(6'h14, 32'h2, 4'hF, r);
        void'(m_write(6'h14, 32'h2, 4'hF));
        axi_read(6'h14, d, r);
        check("done_w1c", d, 32'h0);

        // Reset in the commit cycle of a START write aborts it
        s0 = start_cnt;
        awaddr = 6'h10; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        @(negedge clock);
        check("abort_commit_cycle", bvalid, 1);
        awvalid = 0; wvalid = 0; reset = 1;
        @(negedge clock);
        check("abort_bvalid", bvalid, 0);
        check("abort_awready", awready, 0);
        reset = 0;
        m_reset();
        repeat (3) @(negedge clock);
        check("abort_no_start", start_cnt - s0, 0);
        axi_read(6'h14, d, r);
        check("abort_status", d, 32'h0);
        axi_read(6'h00, d, r);
        check("abort_data0", d, 32'h0);

        // W three cycles ahead of AW, single byte strobe
        awaddr = 6'h00; wdata = 32'hAABBCCDD; wstrb = 4'b0010; wvalid = 1; bready = 0;
        @(negedge clock);
        wvalid = 0;
        check("wfirst_wready_low", wready, 0);
        repeat (2) @(negedge clock);
        check("wfirst_no_bvalid", bvalid, 0);
        awvalid = 1;
        @(negedge clock);
        awvalid = 0;
        check("wfirst_bvalid_1cyc", bvalid, 1);
        check("wfirst_bresp", bresp, 2'b00);
        bready = 1;
        @(negedge clock);
        bready = 0;
        check("wfirst_bvalid_drop", bvalid, 0);
        void'(m_write(6'h00, 32'hAABBCCDD, 4'b0010));
        axi_read(6'h00, d, r);
        check("wfirst_data0", d, 32'h0000CC00);

        // Backpressure on B and R
        awaddr = 6'h04; wdata = 32'h11223344; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        @(negedge clock);
        awvalid = 0; wvalid = 0;
        er = m_write(6'h04, 32'h11223344, 4'hF);
        for (int k = 0; k < 5; k++) begin
            check("bp_bvalid", bvalid, 1);
            check("bp_bresp", bresp, er);
            check("bp_awready", awready, 0);
            check("bp_wready", wready, 0);
            @(negedge clock);
        end
        bready = 1;
        @(negedge clock);
        bready = 0;
        check("bp_bvalid_drop", bvalid, 0);
        araddr = 6'h04; arvalid = 1; rready = 0;
        @(negedge clock);
        arvalid = 0;
        m_read(6'h04, ed, er);
        for (int k = 0; k < 5; k++) begin
            check("bp_rvalid", rvalid, 1);
            check("bp_rdata", rdata, ed);
            check("bp_rresp", rresp, er);
            check("bp_arready", arready, 0);
            @(negedge clock);
        end
        rready = 1;
        @(negedge clock);
        rready = 0;
        check("bp_rvalid_drop", rvalid, 0);

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            int op;
            logic [5:0]  a;
            logic [31:0] rd;
            logic [3:0]  rs;
            op = int'($urandom_range(0, 9));
            a  = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if (op < 4) begin
                rd = $urandom;
                rs = 4'($urandom_range(0, 15));
                axi_write(a, rd, rs, r);
                er = m_write(a, rd, rs);
                check($sformatf("rnd_bresp_a%02h", a), r, er);
            end else if (op < 8) begin
                axi_read(a, d, r);
                m_read(a, ed, er);
                check($sformatf("rnd_rdata_a%02h", a), d, ed);
                check($sformatf("rnd_rresp_a%02h", a), r, er);
            end else if (op == 8) begin
                pulse_done({$urandom, $urandom, $urandom, $urandom});
            end else begin
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
        end
        repeat (3) @(negedge clock);
        check("rnd_data_o", aes_data_o, {m_data[3], m_data[2], m_data[1], m_data[0]});
        check("rnd_start_count", start_cnt, m_starts);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
